// File: rtl/reset_clock_sequencer_if.sv
// rtl/reset_clock_sequencer_if.sv - soft-reset handshake and sequenced reset/enable outputs
interface reset_clock_sequencer_if;
    logic       i_soft_reset_req;
    logic       o_soft_reset_ack;
    logic       o_reset_async_n_sync;
    logic       o_reset_sync;
    logic       o_clock_en;
    logic       o_ready;
    logic [2:0] o_state;

    modport master (
        output i_soft_reset_req,
        input  o_soft_reset_ack,
        input  o_reset_async_n_sync,
        input  o_reset_sync,
        input  o_clock_en,
        input  o_ready,
        input  o_state
    );

    modport slave (
        input  i_soft_reset_req,
        output o_soft_reset_ack,
        output o_reset_async_n_sync,
        output o_reset_sync,
        output o_clock_en,
        output o_ready,
        output o_state
    );
endinterface

// File: rtl/reset_clock_sequencer.sv
// rtl/reset_clock_sequencer.sv - reset synchroniser, reset hold, clock-enable delay and soft-reset handshake
module reset_clock_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_HOLD  = 4,
    parameter int CLKEN_DELAY = 2,
    parameter int CNT_W       = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset_async_n,
    reset_clock_sequencer_if.slave        seq
);

    localparam logic [2:0] ST_SYNC  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(CLKEN_DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   soft_q, soft_d;
    logic                   ack_q, ack_d;
    logic                   ack_set;
    logic                   rst_released;

    assign rst_released = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d = state_q;
        cnt_d   = cnt_q;
        soft_d  = soft_q;
        ack_set = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (rst_released) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = DELAY_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    ack_set = soft_q;
                    soft_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                // a request already acknowledged must be dropped before it can start another run
                if (seq.i_soft_reset_req && !ack_q) begin
                    state_d = ST_DRAIN;
                    soft_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
                soft_d  = 1'b0;
            end
        endcase
        // set wins over clear so a request dropped mid-sequence still gets a one-cycle ack
        if (ack_set) begin
            ack_d = 1'b1;
        end else if (!seq.i_soft_reset_req) begin
            ack_d = 1'b0;
        end else begin
            ack_d = ack_q;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            sync_q  <= '0;
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            soft_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            soft_q  <= soft_d;
            ack_q   <= ack_d;
        end
    end

    assign seq.o_reset_async_n_sync = rst_released;
    assign seq.o_reset_sync         = (state_q == ST_SYNC) || (state_q == ST_HOLD);
    assign seq.o_clock_en           = (state_q == ST_RUN);
    assign seq.o_ready              = (state_q == ST_RUN);
    assign seq.o_soft_reset_ack     = ack_q;
    assign seq.o_state              = state_q;

endmodule

// File: tb/tb_reset_clock_sequencer.sv
// tb/tb_reset_clock_sequencer.sv - randomized check of two sequencer configurations against a timeline model
module tb_reset_clock_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    reset_clock_sequencer_if u_if0 ();
    reset_clock_sequencer_if u_if1 ();

    reset_clock_sequencer u_dut0 (
        .i_clock         (clk),
        .i_reset_async_n (rst_n),
        .seq             (u_if0)
    );

    reset_clock_sequencer #(
        .SYNC_STAGES (3),
        .RESET_HOLD  (1),
        .CLKEN_DELAY (1),
        .CNT_W       (4)
    ) u_dut1 (
        .i_clock         (clk),
        .i_reset_async_n (rst_n),
        .seq             (u_if1)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int ps[2] = '{2, 3};
    int ph[2] = '{4, 1};
    int pd[2] = '{2, 1};
    int soft_k[2]    = '{-1, -1};
    bit ack_m[2]     = '{1'b0, 1'b0};
    int hold_left[2] = '{0, 0};
    bit rand_en      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", tag, got, exp, $time, n);
        end
    endtask

    // state after edge e, counted from hardware release or from the last soft-reset start
    function automatic int exp_state(input int i, input int e);
        int d;
        if (soft_k[i] < 0) begin
            if (e <= ps[i]) return 0;
            d = e - ps[i];
        end else begin
            d = e - soft_k[i];
            if (d == 0) return 4;
        end
        if (d <= ph[i]) return 1;
        if (d <= ph[i] + pd[i]) return 2;
        return 3;
    endfunction

    task automatic set_req(input int i, input bit v);
        if (i == 0) u_if0.i_soft_reset_req = v;
        else        u_if1.i_soft_reset_req = v;
    endtask

    task automatic check_all();
        int st;
        logic [2:0] o_st;
        logic o_sync_n, o_rs, o_en, o_rdy, o_ack;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                o_st = u_if0.o_state; o_sync_n = u_if0.o_reset_async_n_sync; o_rs = u_if0.o_reset_sync;
                o_en = u_if0.o_clock_en; o_rdy = u_if0.o_ready; o_ack = u_if0.o_soft_reset_ack;
            end else begin
                o_st = u_if1.o_state; o_sync_n = u_if1.o_reset_async_n_sync; o_rs = u_if1.o_reset_sync;
                o_en = u_if1.o_clock_en; o_rdy = u_if1.o_ready; o_ack = u_if1.o_soft_reset_ack;
            end
            st = exp_state(i, n);
            chk($sformatf("state%0d", i), 32'(o_st), 32'(st));
            chk($sformatf("sync_n%0d", i), 32'(o_sync_n), 32'(n >= ps[i]));
            chk($sformatf("reset_sync%0d", i), 32'(o_rs), 32'(st <= 1));
            chk($sformatf("clock_en%0d", i), 32'(o_en), 32'(st == 3));
            chk($sformatf("ready%0d", i), 32'(o_rdy), 32'(st == 3));
            chk($sformatf("ack%0d", i), 32'(o_ack), 32'(ack_m[i]));
        end
    endtask

    task automatic hw_assert();
        rst_n = 1'b0;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            soft_k[i] = -1;
            ack_m[i]  = 1'b0;
        end
        #1 check_all();
    endtask

    task automatic hw_release(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic step();
        bit r[2];
        bit old_ack;
        int prev;
        @(posedge clk);
        r[0] = u_if0.i_soft_reset_req;
        r[1] = u_if1.i_soft_reset_req;
        for (int i = 0; i < 2; i++) begin
            prev    = exp_state(i, n);
            old_ack = ack_m[i];
            if (soft_k[i] >= 0 && n + 1 == soft_k[i] + ph[i] + pd[i] + 1) ack_m[i] = 1'b1;
            else if (!r[i]) ack_m[i] = 1'b0;
            if (prev == 3 && r[i] && !old_ack) soft_k[i] = n + 1;
        end
        n++;
        #1 check_all();
        if (rand_en) begin
            for (int i = 0; i < 2; i++) begin
                if (hold_left[i] == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)));
                    hold_left[i] = $urandom_range(1, 25);
                end else begin
                    hold_left[i]--;
                end
            end
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    initial begin
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        #2 hw_assert();
        hw_release(5);

        // power-on, then soft reset held long past ack, then release
        run(12);
        set_req(0, 1'b1); set_req(1, 1'b1);
        run(30);
        set_req(0, 1'b0); set_req(1, 1'b0);
        run(3);
        // request dropped mid-sequence
        set_req(0, 1'b1); set_req(1, 1'b1);
        run(3);
        set_req(0, 1'b0); set_req(1, 1'b0);
        run(12);

        // request pulse during HOLD, then async reset 2ns after an edge while in HOLD
        hw_assert();
        hw_release(2);
        run(3);
        set_req(0, 1'b1); set_req(1, 1'b1);
        run(1);
        set_req(0, 1'b0); set_req(1, 1'b0);
        #1 hw_assert();
        chk("hold_abort_rs", 32'(u_if0.o_reset_sync), 32'd1);
        chk("hold_abort_sn", 32'(u_if0.o_reset_async_n_sync), 32'd0);
        hw_release(2);
        run(10);

        rand_en = 1'b1;
        for (int round = 0; round < 6; round++) begin
            for (int c = 0; c < 300; c++) begin
                step();
                if ($urandom_range(0, 199) == 0) begin
                    hw_assert();
                    hw_release($urandom_range(1, 3));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
